// File: rtl/bank_response_arbiter_pkg.sv
// ==== bank_resp_arb_pkg : shared widths, beat/stat types for the response arbiter ====
// ==== Rev 1.0 ====
`default_nettype none

package bank_resp_arb_pkg;

   localparam int DEF_NUM_BANKS = 16;
   localparam int DEF_ADDR_W    = 32;
   localparam int DEF_DATA_W    = 32;
   localparam int DEF_ID_W      = 32;
   localparam int CYCLE_W       = 64;
   localparam int STAT_W        = 32;

   typedef logic [STAT_W-1:0] stat_cnt_t;

   // Default-width beat as seen by the response queue and statistics loggers.
   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
      logic [DEF_ID_W-1:0]   id;
   } resp_beat_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bank_response_arbiter_if.sv
// ==== bank_response_arbiter_if : per-bank request side plus shared response output ====
// ==== Rev 1.0 ====
`default_nettype none

interface bank_response_arbiter_if
   import bank_resp_arb_pkg::*;
#(
   parameter int NUM_BANKS = DEF_NUM_BANKS,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ID_W      = DEF_ID_W
);
   localparam int IDX_W = idx_width(NUM_BANKS);

   logic [NUM_BANKS-1:0]        in_valid;
   logic [NUM_BANKS-1:0]        in_ready;
   logic [NUM_BANKS*ADDR_W-1:0] in_addr;
   logic [NUM_BANKS*DATA_W-1:0] in_data;
   logic [NUM_BANKS*ID_W-1:0]   in_id;
   logic                        out_valid;
   logic                        out_ready;
   logic [ADDR_W-1:0]           out_addr;
   logic [DATA_W-1:0]           out_data;
   logic [ID_W-1:0]             out_id;
   logic [IDX_W-1:0]            out_bank;
   logic [CYCLE_W-1:0]          out_cycle;

   // slave: the arbiter itself; master: schedulers plus downstream consumer.
   modport slave (
      input  in_valid, in_addr, in_data, in_id, out_ready,
      output in_ready, out_valid, out_addr, out_data, out_id, out_bank, out_cycle
   );

   modport master (
      output in_valid, in_addr, in_data, in_id, out_ready,
      input  in_ready, out_valid, out_addr, out_data, out_id, out_bank, out_cycle
   );

endinterface

`default_nettype wire

// File: rtl/bank_response_arbiter_rr_arbiter.sv
// ==== rr_arbiter : combinational circular priority pick starting at ptr ====
// ==== Rev 1.0 ====
`default_nettype none

module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any_valid
);

   // First pass covers [ptr, N-1]; second pass wraps to [0, ptr-1].
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_valid = 1'b0;
      for (int j = 0; j < N; j++) begin
         if (!any_valid && req[j] && (j >= int'(ptr))) begin
            any_valid = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = IDX_W'(j);
         end
      end
      for (int j = 0; j < N; j++) begin
         if (!any_valid && req[j]) begin
            any_valid = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = IDX_W'(j);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/bank_response_arbiter.sv
// ==== bank_response_arbiter : round-robin share of the memory response channel ====
// ==== Rev 1.0 ; optional statistics via BANK_RESP_ARB_STATS_EN ====
`default_nettype none

module bank_response_arbiter
   import bank_resp_arb_pkg::*;
#(
   parameter int NUM_BANKS = DEF_NUM_BANKS,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ID_W      = DEF_ID_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [CYCLE_W-1:0] global_cycle,
   bank_response_arbiter_if.slave bus
`ifdef BANK_RESP_ARB_STATS_EN
   ,
   output logic [NUM_BANKS*STAT_W-1:0] stat_grants,
   output logic [NUM_BANKS*STAT_W-1:0] stat_max_wait
`endif
);

   localparam int IDX_W = idx_width(NUM_BANKS);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [ID_W-1:0]   id;
   } beat_t;

   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   grant_idx;
   logic [NUM_BANKS-1:0] grant;
   logic               any_valid;
   logic               load;
   beat_t              sel_beat;
   beat_t              out_beat;
   logic [IDX_W-1:0]   out_bank_q;
   logic [CYCLE_W-1:0] out_cycle_q;
   logic               out_valid_q;

   rr_arbiter #(
      .N     (NUM_BANKS),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req       (bus.in_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_valid (any_valid)
   );

   assign load         = !out_valid_q || bus.out_ready;
   assign bus.in_ready = (load && !reset) ? grant : '0;

   always_comb begin
      sel_beat = '0;
      for (int j = 0; j < NUM_BANKS; j++) begin
         if (grant[j]) begin
            sel_beat.addr = bus.in_addr[j*ADDR_W +: ADDR_W];
            sel_beat.data = bus.in_data[j*DATA_W +: DATA_W];
            sel_beat.id   = bus.in_id[j*ID_W +: ID_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         rr_ptr      <= '0;
         out_beat    <= '0;
         out_bank_q  <= '0;
         out_cycle_q <= '0;
      end else if (load) begin
         if (any_valid) begin
            out_valid_q <= 1'b1;
            out_beat    <= sel_beat;
            out_bank_q  <= grant_idx;
            out_cycle_q <= global_cycle;
            rr_ptr      <= (grant_idx == IDX_W'(NUM_BANKS - 1)) ? '0 : grant_idx + 1'b1;
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_addr  = out_beat.addr;
   assign bus.out_data  = out_beat.data;
   assign bus.out_id    = out_beat.id;
   assign bus.out_bank  = out_bank_q;
   assign bus.out_cycle = out_cycle_q;

`ifdef BANK_RESP_ARB_STATS_EN
   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_stats
      stat_cnt_t grants_q;
      stat_cnt_t wait_q;
      stat_cnt_t max_q;
      stat_cnt_t wait_inc;

      assign wait_inc = wait_q + 1'b1;

      // All counters saturate rather than wrap.
      always_ff @(posedge clk) begin
         if (reset) begin
            grants_q <= '0;
            wait_q   <= '0;
            max_q    <= '0;
         end else if (bus.in_ready[b]) begin
            wait_q <= '0;
            if (grants_q != '1) grants_q <= grants_q + 1'b1;
         end else if (bus.in_valid[b] && (wait_q != '1)) begin
            wait_q <= wait_inc;
            if (wait_inc > max_q) max_q <= wait_inc;
         end
      end

      assign stat_grants[b*STAT_W +: STAT_W]   = grants_q;
      assign stat_max_wait[b*STAT_W +: STAT_W] = max_q;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bank_response_arbiter.sv
// ==== tb_bank_response_arbiter : directed self-checking bench (4- and 5-bank instances) ====
// ==== Rev 1.0 ====
`default_nettype none

module tb_bank_response_arbiter;
   import bank_resp_arb_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] gcycle = 64'd0;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   bank_response_arbiter_if #(.NUM_BANKS(4)) a_if ();
   bank_response_arbiter_if #(.NUM_BANKS(5)) b_if ();

`ifdef BANK_RESP_ARB_STATS_EN
   logic [4*32-1:0] a_grants, a_max_wait;
   logic [5*32-1:0] b_grants, b_max_wait;
`endif

   bank_response_arbiter #(.NUM_BANKS(4)) u_dut_a (
      .clk           (clk),
      .reset         (reset),
      .global_cycle  (gcycle),
      .bus           (a_if)
`ifdef BANK_RESP_ARB_STATS_EN
      ,
      .stat_grants   (a_grants),
      .stat_max_wait (a_max_wait)
`endif
   );

   bank_response_arbiter #(.NUM_BANKS(5)) u_dut_b (
      .clk           (clk),
      .reset         (reset),
      .global_cycle  (gcycle),
      .bus           (b_if)
`ifdef BANK_RESP_ARB_STATS_EN
      ,
      .stat_grants   (b_grants),
      .stat_max_wait (b_max_wait)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input int b, input logic [31:0] addr, input logic [31:0] data, input logic [31:0] id);
      a_if.in_addr[b*32 +: 32] = addr;
      a_if.in_data[b*32 +: 32] = data;
      a_if.in_id[b*32 +: 32]   = id;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      a_if.in_valid = '0; a_if.in_addr = '0; a_if.in_data = '0; a_if.in_id = '0; a_if.out_ready = 1'b0;
      b_if.in_valid = '0; b_if.in_addr = '0; b_if.in_data = '0; b_if.in_id = '0; b_if.out_ready = 1'b0;

      // Reset state, with requests present to confirm in_ready is masked.
      reset = 1'b1;
      a_if.in_valid = 4'hF;
      tick(); tick();
      chk("rst_out_valid", 64'(a_if.out_valid), 64'd0);
      chk("rst_out_addr",  64'(a_if.out_addr),  64'd0);
      chk("rst_out_data",  64'(a_if.out_data),  64'd0);
      chk("rst_out_id",    64'(a_if.out_id),    64'd0);
      chk("rst_out_bank",  64'(a_if.out_bank),  64'd0);
      chk("rst_out_cycle", a_if.out_cycle,      64'd0);
      chk("rst_in_ready",  64'(a_if.in_ready),  64'd0);
      reset = 1'b0;
      a_if.in_valid = '0;
      tick();

      // Single request from bank 2.
      set_a(2, 32'h100, 32'hD2, 32'd7);
      a_if.in_valid  = 4'b0100;
      a_if.out_ready = 1'b1;
      gcycle = 64'd50;
      #1;
      chk("single_in_ready", 64'(a_if.in_ready), 64'b0100);
      tick();
      a_if.in_valid = '0;
      chk("single_out_valid", 64'(a_if.out_valid), 64'd1);
      chk("single_out_bank",  64'(a_if.out_bank),  64'd2);
      chk("single_out_addr",  64'(a_if.out_addr),  64'h100);
      chk("single_out_data",  64'(a_if.out_data),  64'hD2);
      chk("single_out_id",    64'(a_if.out_id),    64'd7);
      chk("single_out_cycle", a_if.out_cycle,      64'd50);

      // All four valid from reset: grant order 0,1,2,3,0 with no bubbles.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rr_rst_out_valid", 64'(a_if.out_valid), 64'd0);
      for (int b = 0; b < 4; b++) set_a(b, 32'hA0 + 32'(b), 32'hC0 + 32'(b), 32'(b));
      a_if.in_valid = 4'hF;
      for (int k = 0; k < 5; k++) begin
         gcycle = 64'd100 + 64'(k);
         #1;
         chk("rr_in_ready", 64'(a_if.in_ready), 64'(1 << (k % 4)));
         tick();
         chk("rr_out_valid", 64'(a_if.out_valid), 64'd1);
         chk("rr_out_bank",  64'(a_if.out_bank),  64'(k % 4));
         chk("rr_out_addr",  64'(a_if.out_addr),  64'h0A0 + 64'(k % 4));
         chk("rr_out_cycle", a_if.out_cycle,      64'd100 + 64'(k));
      end

      // Stall with bank 1 waiting; output must hold and no grants issued.
      a_if.in_valid  = 4'b0010;
      a_if.out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         gcycle = 64'd150 + 64'(k);
         #1;
         chk("stall_in_ready", 64'(a_if.in_ready), 64'd0);
         tick();
         chk("stall_out_valid", 64'(a_if.out_valid), 64'd1);
         chk("stall_out_bank",  64'(a_if.out_bank),  64'd0);
         chk("stall_out_cycle", a_if.out_cycle,      64'd104);
      end
      a_if.out_ready = 1'b1;
      gcycle = 64'd200;
      #1;
      chk("release_in_ready", 64'(a_if.in_ready), 64'b0010);
      tick();
      chk("release_out_bank",  64'(a_if.out_bank),  64'd1);
      chk("release_out_addr",  64'(a_if.out_addr),  64'hA1);
      chk("release_out_cycle", a_if.out_cycle,      64'd200);

      // Reset during stall: held beat dropped, pointer back to 0.
      a_if.out_ready = 1'b0;
      a_if.in_valid  = 4'b1000;
      tick();
      chk("rstall_in_ready",  64'(a_if.in_ready), 64'd0);
      chk("rstall_out_bank",  64'(a_if.out_bank), 64'd1);
      reset = 1'b1;
      #1;
      chk("rstall_rst_in_ready", 64'(a_if.in_ready), 64'd0);
      tick();
      reset = 1'b0;
      chk("rstall_out_valid", 64'(a_if.out_valid), 64'd0);
      chk("rstall_out_bank0", 64'(a_if.out_bank),  64'd0);
      a_if.in_valid  = 4'b1010;
      a_if.out_ready = 1'b1;
      #1;
      chk("rstall_next_in_ready", 64'(a_if.in_ready), 64'b0010);
      tick();
      chk("rstall_next_bank", 64'(a_if.out_bank), 64'd1);
      chk("rstall_next_addr", 64'(a_if.out_addr), 64'hA1);
      a_if.in_valid = '0;

      // Five banks: move pointer to 4, then wrap from 4 to 0.
      for (int b = 0; b < 5; b++) b_if.in_addr[b*32 +: 32] = 32'hB0 + 32'(b);
      b_if.out_ready = 1'b1;
      b_if.in_valid  = 5'b01000;
      #1;
      chk("wrap_pre_in_ready", 64'(b_if.in_ready), 64'b01000);
      tick();
      chk("wrap_pre_bank", 64'(b_if.out_bank), 64'd3);
      b_if.in_valid = 5'b10001;
      #1;
      chk("wrap_first_in_ready", 64'(b_if.in_ready), 64'b10000);
      tick();
      chk("wrap_first_bank", 64'(b_if.out_bank), 64'd4);
      chk("wrap_first_addr", 64'(b_if.out_addr), 64'hB4);
      b_if.in_valid = 5'b00001;
      #1;
      chk("wrap_second_in_ready", 64'(b_if.in_ready), 64'b00001);
      tick();
      chk("wrap_second_bank", 64'(b_if.out_bank), 64'd0);
      chk("wrap_second_addr", 64'(b_if.out_addr), 64'hB0);
      b_if.in_valid = '0;
      tick();
      chk("drain_out_valid", 64'(b_if.out_valid), 64'd0);

`ifdef BANK_RESP_ARB_STATS_EN
      // Bank 3 waits three cycles behind banks 0..2.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("stat_rst_grants3", 64'(a_grants[3*32 +: 32]), 64'd0);
      a_if.in_valid  = 4'hF;
      a_if.out_ready = 1'b1;
      tick(); tick(); tick(); tick();
      a_if.in_valid = '0;
      chk("stat_max_wait3", 64'(a_max_wait[3*32 +: 32]), 64'd3);
      for (int b = 0; b < 4; b++) chk("stat_grants", 64'(a_grants[b*32 +: 32]), 64'd1);
`endif

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bank_response_arbiter.md
# bank_response_arbiter

Round-robin arbiter that shares the single physical-memory response channel among `NUM_BANKS` per-bank schedulers. Each scheduler offers one response beat (address, data, request ID) on a valid/ready port. The arbiter grants one per cycle into a one-entry output register, tagged with the winning bank index and the grant-cycle timestamp. The output feeds the response queue and the per-bank response statistics loggers.

## Interface
Parameters:
- `NUM_BANKS`, default 16: number of requesting bank schedulers, ≥2; power of two not required.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `ID_W`, default 32: request ID width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `global_cycle`  in  64  free-running cycle count.
- `in_valid`  in  NUM_BANKS  per-bank response valid.
- `in_ready`  out  NUM_BANKS  per-bank accept; one-hot or zero.
- `in_addr`  in  NUM_BANKS*ADDR_W  flattened; bank i at `[i*ADDR_W +: ADDR_W]`.
- `in_data`  in  NUM_BANKS*DATA_W  flattened, same packing.
- `in_id`  in  NUM_BANKS*ID_W  flattened, same packing.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accept.
- `out_addr` / `out_data` / `out_id`  out  ADDR_W / DATA_W / ID_W  granted payload.
- `out_bank`  out  max(1,$clog2(NUM_BANKS))  index of the granted bank.
- `out_cycle`  out  64  `global_cycle` value in the grant cycle.

## Operation
- `load = !out_valid || out_ready`.
- On `load` with any `in_valid` set:
  - The grant is the first set bit at or after `rr_ptr`, searching circularly.
  - `in_ready[grant]=1` in that cycle. The payload, `out_bank` and `out_cycle` are registered, and `out_valid<=1`.
  - `rr_ptr <= grant+1`, wrapping `NUM_BANKS-1 → 0`.
- On `load` with no `in_valid` set: `out_valid<=0`. `rr_ptr` and payload registers hold.
- When `!load`: `in_ready` is all-zero and all registers hold.
- `in_ready` is combinational from `in_valid`, `rr_ptr`, `out_valid` and `out_ready`. The `out_ready→in_ready` path is intentional.
- Requesters hold `in_valid` and payload until accepted. The arbiter does not check this.
- Fairness: a continuously valid requester is granted within `NUM_BANKS` consecutive grants.

## Timing
- Reset values:
  - `out_valid=0`, `rr_ptr=0`.
  - `out_addr`, `out_data`, `out_id`, `out_bank`, `out_cycle` all 0.
  - `in_ready=0` while `reset` is high.
- Latency is 1 cycle, `in_valid&in_ready` → `out_valid`. Throughput is 1 beat/cycle when `out_ready` is held high.
- Backpressure: while `out_valid && !out_ready`, the output is stable and no grants are issued.
- A simultaneous drain and refill in one cycle gives no bubble.
- Reset asserted mid-stall discards the held beat. The requester is not re-acknowledged.
- With a single requester valid, it is granted regardless of `rr_ptr`.

## Configuration
- `BANK_RESP_ARB_STATS_EN` defined: adds outputs `stat_grants` (NUM_BANKS*32) and `stat_max_wait` (NUM_BANKS*32). Both are flattened, with bank i at `[i*32 +: 32]`.
  - Per-bank grant counters saturate at `32'hFFFF_FFFF`.
  - Per-bank wait counter increments each cycle `in_valid && !in_ready` and clears on grant.
  - `stat_max_wait[i]` records the largest wait observed.
  - All stats reset to 0.
- Undefined: these ports and all their logic are absent. The arbitration behaviour is identical in both cases.

## Structure
- Package `bank_resp_arb_pkg` holds:
  - Default width constants.
  - `resp_beat_t`, a packed struct of addr/data/id.
  - The `stat_cnt_t` 32-bit type.
- Sub-module `rr_arbiter`: a combinational circular priority pick from a request vector and `rr_ptr`, giving a one-hot grant, a binary index and an any-valid flag. The pointer register stays in the parent.

## Test plan
- Reset, then single request: `NUM_BANKS=4`; bank 2 valid, addr `0x100`, id 7, `global_cycle=50`, `out_ready=1` → `in_ready=4'b0100`; next cycle `out_valid=1`, `out_bank=2`, `out_addr=0x100`, `out_cycle=50`.
- All four banks valid continuously, `out_ready=1`, from reset → grant order 0,1,2,3,0; one beat per cycle; no bubbles.
- Stall: `out_ready=0` for 5 cycles with bank 1 beat held → output unchanged; `in_ready=0` throughout; on release, the next grant follows in the same cycle.
- Wrap with non-power-of-2: `NUM_BANKS=5`, `rr_ptr=4`, banks 4 and 0 valid → bank 4 first, then bank 0.
- Reset during stall: beat held, `reset` pulsed one cycle → `out_valid=0`, `rr_ptr=0`; the next grant goes to the lowest valid bank.
- With `BANK_RESP_ARB_STATS_EN`: bank 3 waits 3 cycles behind banks 0–2 → `stat_max_wait[3]=3`, `stat_grants` each 1.
